// File: rtl/music_sequencer.sv
// music_sequencer: beat-index sequencer with play/pause, direction, speed and restart control
module music_sequencer #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BEATLENGTH = 115,
  parameter int unsigned FAST_HZ    = 8,
  parameter int unsigned SLOW_HZ    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play_pulse,
  input  logic       restart_pulse,
  input  logic       up_pulse,
  input  logic       down_pulse,
  input  logic       speed_pulse,
  output logic [7:0] ibeat,
  output logic       beat_tick,
  output logic       tone_en,
  output logic       dir,
  output logic       slow
);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;
  localparam logic [31:0] DIV_FAST = 32'(CLK_FREQ / FAST_HZ);
  localparam logic [31:0] DIV_SLOW = 32'(CLK_FREQ / SLOW_HZ);
  localparam logic [7:0]  LAST     = 8'(BEATLENGTH);
  state_t      state_q, state_d;
  logic [7:0]  ibeat_q, ibeat_d;
  logic [31:0] div_q, div_d, div_max;
  logic        tick_q, tick_d, tone_q, dir_q, dir_d, slow_q, slow_d, step, at_edge;
  assign div_max   = (slow_q ? DIV_SLOW : DIV_FAST) - 32'd1;
  assign at_edge   = dir_q ? (ibeat_q == LAST) : (ibeat_q == 8'd0);
  assign step      = (state_q == PLAY) && !restart_pulse && !play_pulse && !speed_pulse && (div_q == div_max);
  assign ibeat     = ibeat_q;
  assign beat_tick = tick_q;
  assign tone_en   = tone_q;
  assign dir       = dir_q;
  assign slow      = slow_q;
  // Pulse priority restart > play > up > down, then the period-end beat step; a speed change restarts the period
  always_comb begin
    state_d = state_q;
    ibeat_d = ibeat_q;
    dir_d   = dir_q;
    slow_d  = speed_pulse ? ~slow_q : slow_q;
    tick_d  = step && !at_edge;
    if (restart_pulse) begin
      state_d = PLAY;
      ibeat_d = 8'd0;
      dir_d   = 1'b1;
    end else if (play_pulse) begin
      state_d = (state_q == IDLE || state_q == PAUSE) ? PLAY : (state_q == PLAY) ? PAUSE : state_q;
    end else if (up_pulse) begin
      dir_d   = 1'b1;
      state_d = (state_q == DONE && ibeat_q != LAST) ? PLAY : state_q;
    end else if (down_pulse) begin
      dir_d   = 1'b0;
      state_d = (state_q == DONE && ibeat_q != 8'd0) ? PLAY : state_q;
    end
    if (step) begin
      state_d = at_edge ? DONE : state_d;
      ibeat_d = at_edge ? ibeat_q : (dir_q ? ibeat_q + 8'd1 : ibeat_q - 8'd1);
    end
    div_d = (state_q == PLAY && state_d == PLAY && !restart_pulse && !speed_pulse && !step) ? div_q + 32'd1 : 32'd0;
  end
  // State and registered outputs; reset aborts anything in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ibeat_q <= 8'd0;
      div_q   <= 32'd0;
      tick_q  <= 1'b0;
      tone_q  <= 1'b0;
      dir_q   <= 1'b1;
      slow_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ibeat_q <= ibeat_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      tone_q  <= (state_d == PLAY);
      dir_q   <= dir_d;
      slow_q  <= slow_d;
    end
  end
endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: directed and random checks of music_sequencer against a behavioural model
module tb_music_sequencer;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DONE = 3, LASTB = 5;
  logic       clk = 1'b0, rst = 1'b1;
  logic       play_pulse = 0, restart_pulse = 0, up_pulse = 0, down_pulse = 0, speed_pulse = 0;
  logic [7:0] ibeat;
  logic       beat_tick, tone_en, dir, slow;
  int         checks = 0, failures = 0;
  int         m_mode, m_beat, m_dir, m_slow, m_el, m_tick;

  music_sequencer #(.CLK_FREQ(64), .BEATLENGTH(5), .FAST_HZ(8), .SLOW_HZ(4)) dut (
    .clk(clk), .rst(rst), .play_pulse(play_pulse), .restart_pulse(restart_pulse),
    .up_pulse(up_pulse), .down_pulse(down_pulse), .speed_pulse(speed_pulse),
    .ibeat(ibeat), .beat_tick(beat_tick), .tone_en(tone_en), .dir(dir), .slow(slow));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_ibeat"}, 32'(ibeat), 32'(m_beat));
    chk({tag, "_tick"}, 32'(beat_tick), 32'(m_tick));
    chk({tag, "_tone"}, 32'(tone_en), 32'(m_mode == M_PLAY));
    chk({tag, "_dir"}, 32'(dir), 32'(m_dir));
    chk({tag, "_slow"}, 32'(slow), 32'(m_slow));
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_beat = 0; m_dir = 1; m_slow = 1; m_el = 0; m_tick = 0;
  endtask

  // One clock of the musical behaviour: elapsed cycles of the current beat reach the period -> next beat
  task automatic model_step(input logic p, r, u, d, s);
    int per;
    int old_dir;
    bit advance;
    per = 64 / (m_slow ? 4 : 8);
    old_dir = m_dir;
    advance = (m_mode == M_PLAY) && !r && !p && !s;
    m_tick = 0;
    if (r) begin
      m_mode = M_PLAY; m_beat = 0; m_dir = 1;
    end else if (p) begin
      if (m_mode == M_IDLE || m_mode == M_PAUSE) m_mode = M_PLAY;
      else if (m_mode == M_PLAY) m_mode = M_PAUSE;
    end else if (u) begin
      m_dir = 1;
      if (m_mode == M_DONE && m_beat < LASTB) m_mode = M_PLAY;
    end else if (d) begin
      m_dir = 0;
      if (m_mode == M_DONE && m_beat > 0) m_mode = M_PLAY;
    end
    if (advance) begin
      m_el++;
      if (m_el == per) begin
        m_el = 0;
        if (old_dir ? (m_beat == LASTB) : (m_beat == 0)) m_mode = M_DONE;
        else begin
          m_beat = old_dir ? m_beat + 1 : m_beat - 1;
          m_tick = 1;
        end
      end
    end else m_el = 0;
    if (s) m_slow = !m_slow;
  endtask

  task automatic cyc(input logic p, r, u, d, s);
    @(negedge clk);
    play_pulse = p; restart_pulse = r; up_pulse = u; down_pulse = d; speed_pulse = s;
    @(posedge clk);
    model_step(p, r, u, d, s);
    #1 chk_model("cyc");
    play_pulse = 0; restart_pulse = 0; up_pulse = 0; down_pulse = 0; speed_pulse = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic run_to_beat(input int b);
    int guard;
    guard = 0;
    while (m_beat != b && guard < 300) begin
      cyc(0, 0, 0, 0, 0);
      guard++;
    end
    chk("reach_beat", 32'(ibeat), 32'(b));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    #1 chk_model("reset");
    cyc(1, 0, 0, 0, 0);
    chk("play_tone", 32'(tone_en), 32'd1);
    idle(15);
    chk("pre_step_beat", 32'(ibeat), 32'd0);
    idle(1);
    chk("first_step_beat", 32'(ibeat), 32'd1);
    chk("first_step_tick", 32'(beat_tick), 32'd1);
    idle(1);
    chk("tick_one_cycle", 32'(beat_tick), 32'd0);
    idle(100);
    chk("done_beat", 32'(ibeat), 32'd5);
    chk("done_tone", 32'(tone_en), 32'd0);
    cyc(1, 0, 0, 0, 0);
    chk("done_play_ignored", 32'(tone_en), 32'd0);
    cyc(0, 0, 0, 1, 0);
    chk("done_down_tone", 32'(tone_en), 32'd1);
    idle(16);
    chk("done_down_beat", 32'(ibeat), 32'd4);
    cyc(0, 1, 0, 0, 0);
    run_to_beat(3);
    idle(3);
    cyc(0, 0, 0, 0, 1);
    chk("speed_slow", 32'(slow), 32'd0);
    idle(7);
    chk("speed_pre_step", 32'(ibeat), 32'd3);
    idle(1);
    chk("speed_step", 32'(ibeat), 32'd4);
    cyc(1, 0, 0, 0, 0);
    chk("pause_tone", 32'(tone_en), 32'd0);
    idle(50);
    chk("pause_hold", 32'(ibeat), 32'd4);
    cyc(1, 0, 0, 0, 0);
    idle(8);
    chk("resume_step", 32'(ibeat), 32'd5);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    run_to_beat(4);
    cyc(1, 1, 0, 1, 0);
    chk("multi_beat", 32'(ibeat), 32'd0);
    chk("multi_dir", 32'(dir), 32'd1);
    chk("multi_tone", 32'(tone_en), 32'd1);
    cyc(0, 0, 0, 1, 0);
    idle(20);
    chk("underflow_beat", 32'(ibeat), 32'd0);
    chk("underflow_tone", 32'(tone_en), 32'd0);
    cyc(0, 1, 0, 0, 0);
    idle(20);
    cyc(0, 0, 0, 0, 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_ibeat", 32'(ibeat), 32'd0);
    chk("arst_tone", 32'(tone_en), 32'd0);
    chk("arst_tick", 32'(beat_tick), 32'd0);
    chk("arst_dir", 32'(dir), 32'd1);
    chk("arst_slow", 32'(slow), 32'd1);
    model_reset();
    @(negedge clk);
    play_pulse = 1; restart_pulse = 1; speed_pulse = 1; down_pulse = 1;
    @(posedge clk);
    #1 chk_model("rst_pulses");
    play_pulse = 0; restart_pulse = 0; speed_pulse = 0; down_pulse = 0;
    @(negedge clk) rst = 0;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0, $urandom_range(0, 30) == 0,
          $urandom_range(0, 30) == 0, $urandom_range(0, 60) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BEATLENGTH, default 115, meaning last valid beat index.
REQ-003 SHALL have parameter FAST_HZ, default 8, meaning beat rate in fast mode.
REQ-004 SHALL have parameter SLOW_HZ, default 4, meaning beat rate in slow mode.
REQ-005 SHALL have port clk, input, 1, system clock; one clock only.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port play_pulse, input, 1, one-cycle pulse that toggles play/pause.
REQ-008 SHALL have port restart_pulse, input, 1, one-cycle pulse that rewinds to beat 0 and plays ascending.
REQ-009 SHALL have port up_pulse, input, 1, one-cycle pulse that selects ascending direction.
REQ-010 SHALL have port down_pulse, input, 1, one-cycle pulse that selects descending direction.
REQ-011 SHALL have port speed_pulse, input, 1, one-cycle pulse that toggles fast/slow.
REQ-012 SHALL have port ibeat, output, 8, current beat index to the tone table.
REQ-013 SHALL have port beat_tick, output, 1, one-cycle pulse, asserted in the same cycle that ibeat changes.
REQ-014 SHALL have port tone_en, output, 1, high only in PLAY; low mutes the tone generator.
REQ-015 SHALL have port dir, output, 1, 1=ascending, 0=descending.
REQ-016 SHALL have port slow, output, 1, 1=SLOW_HZ, 0=FAST_HZ.

Function
REQ-017 SHALL implement states IDLE, PLAY, PAUSE, DONE; state held in registers clocked on clk.
REQ-018 SHALL compute DIV = CLK_FREQ/(slow ? SLOW_HZ : FAST_HZ), using 32-bit integer division.
REQ-019 SHALL increment div_cnt each clk only in PLAY; when div_cnt==DIV-1, div_cnt SHALL go to 0 and a beat step SHALL occur.
REQ-020 Beat step: ibeat±1 per dir registered, with beat_tick=1 for exactly that cycle; first step SHALL occur DIV cycles after entering PLAY.
REQ-021 Ascending with ibeat==BEATLENGTH, or descending with ibeat==0, at a step: ibeat SHALL hold, beat_tick SHALL stay 0, and state SHALL go to DONE; ibeat SHALL never wrap.
REQ-022 Outside PLAY, div_cnt SHALL be held at 0 and beat_tick SHALL stay 0.
REQ-023 IDLE: play_pulse -> PLAY; restart_pulse -> PLAY.
REQ-024 PLAY: play_pulse -> PAUSE; ibeat and dir SHALL be preserved.
REQ-025 PAUSE: play_pulse -> PLAY; div_cnt SHALL restart from 0.
REQ-026 DONE: play_pulse has no effect; a direction pulse that allows motion away from the boundary SHALL move to PLAY with div_cnt=0.
REQ-027 restart_pulse in any state SHALL set ibeat=0, dir=1, div_cnt=0, state=PLAY, with effect on the next clk edge.
REQ-028 up_pulse SHALL set dir=1; down_pulse SHALL set dir=0; both are legal in every state.
REQ-029 speed_pulse SHALL toggle slow and clear div_cnt to 0; the current beat SHALL restart its full new period.
REQ-030 Simultaneous pulses SHALL be resolved with priority restart > play > up > down; speed_pulse SHALL apply independently in the same cycle, except that restart also clears div_cnt.
REQ-031 All outputs SHALL be registered; tone_en SHALL equal (state==PLAY) registered, changing on the same edge as the state.

Reset
REQ-032 On rst=1, asynchronously: state=IDLE, ibeat=0, div_cnt=0, beat_tick=0, tone_en=0, dir=1, slow=1.
REQ-033 Pulses received while rst=1 SHALL be ignored; assertion of rst mid-PLAY SHALL abort immediately to the REQ-032 values.

Verification (CLK_FREQ=64, FAST_HZ=8, SLOW_HZ=4, BEATLENGTH=5, so fast DIV=8 and slow DIV=16)
REQ-034 Reset, then play_pulse -> tone_en=1 next cycle; ibeat 0->1 after 16 cycles with a one-cycle beat_tick; further steps every 16 cycles.
REQ-035 Play to the end: ibeat reaches 5, next step -> DONE, tone_en=0, ibeat stays 5; down_pulse -> PLAY, ibeat=4 after 16 cycles.
REQ-036 In PLAY at ibeat=3, speed_pulse -> div_cnt=0 and slow=0; next step 8 cycles later; then play_pulse -> PAUSE; hold 50 cycles with ibeat unchanged; play_pulse resumes with a step 8 cycles later.
REQ-037 Same-cycle restart_pulse+down_pulse+play_pulse at ibeat=4 -> ibeat=0, dir=1, state PLAY.
REQ-038 rst asserted mid-PLAY between clk edges -> outputs take the REQ-032 values without waiting for a clk edge.
REQ-039 At ibeat=0 descending in PLAY -> DONE with no underflow to 255.
